// File: rtl/riscuinho_ng_pkg.sv
// Shared types and defaults for the riscuinho_ng test monitor.
package riscuinho_ng_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StPass    = 2'd1,
    StFail    = 2'd2,
    StTimeout = 2'd3
  } mon_state_t;

  localparam logic [31:0] TohostAddrDefault  = 32'h0000_0FF0;
  localparam logic [31:0] ConsoleAddrDefault = 32'h0000_0FF4;

  // Expand byte enables into a 32-bit data mask.
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/riscuinho_ng_wdog.sv
// Saturating cycle counter with watchdog expiry compare; counts only while enabled.
module riscuinho_ng_wdog #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] cycles,
  output logic        expire
);

  localparam bit          WdogOn    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LastCycle = WdogOn ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [31:0] cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
    end else if (en && (cycles_q != '1)) begin
      cycles_q <= cycles_q + 32'd1;
    end
  end

  assign cycles = cycles_q;
  assign expire = WdogOn && en && (cycles_q == LastCycle);

endmodule

// File: rtl/riscuinho_ng_test_monitor.sv
// Store-traffic snooper: end-of-test detection, exit code, watchdog, signature and console.
module riscuinho_ng_test_monitor
  import riscuinho_ng_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR    = TohostAddrDefault,
  parameter logic [31:0] CONSOLE_ADDR   = ConsoleAddrDefault,
  parameter logic [31:0] SIG_BASE       = 32'h0000_0000,
  parameter int unsigned SIG_WORDS      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_ready,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic [3:0]  bus_wstrb,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [30:0] exit_code,
  output logic [31:0] cycles,
  output logic [31:0] sig,
  output logic [15:0] sig_count,
  output logic        con_valid,
  output logic [7:0]  con_char
);

  // 33-bit bounds so a window ending at the top of memory cannot wrap.
  localparam logic [32:0] SigLo = {1'b0, SIG_BASE};
  localparam logic [32:0] SigHi = {1'b0, SIG_BASE} + 33'(4 * SIG_WORDS);

  mon_state_t  state_q, state_d;
  logic [30:0] exit_q, exit_d;
  logic [31:0] sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic        con_valid_q, con_valid_d;
  logic [7:0]  con_char_q, con_char_d;

  logic running, expire, xfer, hit_tohost, hit_con, hit_sig;

  assign running    = (state_q == StRun);
  assign xfer       = bus_valid & bus_ready & bus_we;
  assign hit_tohost = xfer && (bus_addr[31:2] == TOHOST_ADDR[31:2]) && (bus_wstrb == 4'hF);
  assign hit_con    = xfer && (bus_addr[31:2] == CONSOLE_ADDR[31:2]) && bus_wstrb[0];
  assign hit_sig    = xfer && ({1'b0, bus_addr} >= SigLo) && ({1'b0, bus_addr} < SigHi);

  riscuinho_ng_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (running),
    .cycles(cycles),
    .expire(expire)
  );

  always_comb begin
    state_d     = state_q;
    exit_d      = exit_q;
    sig_d       = sig_q;
    cnt_d       = cnt_q;
    con_valid_d = hit_con;
    con_char_d  = hit_con ? bus_wdata[7:0] : con_char_q;
    if (running) begin
      // Even TOHOST values are not end-of-test markers; TOHOST outranks expiry.
      if (hit_tohost && bus_wdata[0]) begin
        if (bus_wdata == 32'd1) begin
          state_d = StPass;
        end else begin
          state_d = StFail;
          exit_d  = bus_wdata[31:1];
        end
      end else if (expire) begin
        state_d = StTimeout;
      end
      if (hit_sig) begin
        sig_d = {sig_q[30:0], sig_q[31]} ^ (bus_wdata & strb_mask(bus_wstrb));
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      exit_q      <= '0;
      sig_q       <= '0;
      cnt_q       <= '0;
      con_valid_q <= 1'b0;
      con_char_q  <= '0;
    end else begin
      state_q     <= state_d;
      exit_q      <= exit_d;
      sig_q       <= sig_d;
      cnt_q       <= cnt_d;
      con_valid_q <= con_valid_d;
      con_char_q  <= con_char_d;
    end
  end

  assign done      = (state_q != StRun);
  assign pass      = (state_q == StPass);
  assign timeout   = (state_q == StTimeout);
  assign exit_code = exit_q;
  assign sig       = sig_q;
  assign sig_count = cnt_q;
  assign con_valid = con_valid_q;
  assign con_char  = con_char_q;

endmodule

// File: tb/tb_riscuinho_ng_test_monitor.sv
// Directed bench: long-watchdog instance for most scenarios, 50-cycle instance for timeouts.
module tb_riscuinho_ng_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_valid = 1'b0, bus_ready = 1'b0, bus_we = 1'b0;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic [3:0]  bus_wstrb = '0;

  logic        l_done, l_pass, l_timeout, l_con_valid;
  logic [30:0] l_exit;
  logic [31:0] l_cycles, l_sig;
  logic [15:0] l_cnt;
  logic [7:0]  l_con_char;

  logic        s_done, s_pass, s_timeout, s_con_valid;
  logic [30:0] s_exit;
  logic [31:0] s_cycles, s_sig;
  logic [15:0] s_cnt;
  logic [7:0]  s_con_char;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  riscuinho_ng_test_monitor u_long (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .done(l_done), .pass(l_pass), .timeout(l_timeout), .exit_code(l_exit), .cycles(l_cycles),
    .sig(l_sig), .sig_count(l_cnt), .con_valid(l_con_valid), .con_char(l_con_char)
  );

  riscuinho_ng_test_monitor #(.TIMEOUT_CYCLES(50)) u_short (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .done(s_done), .pass(s_pass), .timeout(s_timeout), .exit_code(s_exit), .cycles(s_cycles),
    .sig(s_sig), .sig_count(s_cnt), .con_valid(s_con_valid), .con_char(s_con_char)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset, then release on a falling edge so the next rising edge is cycle 1.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic rdy);
    bus_valid = 1'b1; bus_ready = rdy; bus_we = 1'b1;
    bus_addr = a; bus_wdata = d; bus_wstrb = s;
    tick();
    bus_valid = 1'b0; bus_ready = 1'b0; bus_we = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
  endtask

  initial begin
    #2;
    check("rst_done", 32'(l_done), 32'd0);
    check("rst_pass", 32'(l_pass), 32'd0);
    check("rst_cycles", l_cycles, 32'd0);
    check("rst_sig", l_sig, 32'd0);
    check("rst_con", {23'd0, l_con_valid, l_con_char}, 32'd0);

    // 1: PASS at cycle 200, cycles freeze at 201
    @(negedge clk);
    do_reset();
    repeat (200) tick();
    check("t1_prerun_done", 32'(l_done), 32'd0);
    store(32'h0FF0, 32'h1, 4'hF, 1'b1);
    check("t1_done", 32'(l_done), 32'd1);
    check("t1_pass", 32'(l_pass), 32'd1);
    check("t1_exit", 32'(l_exit), 32'd0);
    check("t1_cycles", l_cycles, 32'd201);
    repeat (5) tick();
    check("t1_cycles_frozen", l_cycles, 32'd201);

    // 2: FAIL with exit code 3; later PASS store ignored; console still forwarded
    do_reset();
    repeat (3) tick();
    store(32'h0FF0, 32'h7, 4'hF, 1'b1);
    check("t2_done", 32'(l_done), 32'd1);
    check("t2_pass", 32'(l_pass), 32'd0);
    check("t2_exit", 32'(l_exit), 32'd3);
    store(32'h0FF0, 32'h1, 4'hF, 1'b1);
    check("t2_pass_after", 32'(l_pass), 32'd0);
    check("t2_exit_after", 32'(l_exit), 32'd3);
    store(32'h0FF4, 32'h5A, 4'h1, 1'b1);
    check("t2_con_after_done", {23'd0, l_con_valid, l_con_char}, 32'h15A);

    // 3a: watchdog expiry on the short instance
    do_reset();
    repeat (49) tick();
    check("t3_timeout_early", 32'(s_timeout), 32'd0);
    tick();
    check("t3_timeout", 32'(s_timeout), 32'd1);
    check("t3_done", 32'(s_done), 32'd1);
    check("t3_cycles", s_cycles, 32'd50);
    check("t3_long_running", 32'(l_done), 32'd0);
    repeat (3) tick();
    check("t3_cycles_frozen", s_cycles, 32'd50);

    // 3b: TOHOST on the expiry cycle wins
    do_reset();
    repeat (49) tick();
    store(32'h0FF0, 32'h1, 4'hF, 1'b1);
    check("t3b_pass", 32'(s_pass), 32'd1);
    check("t3b_timeout", 32'(s_timeout), 32'd0);

    // 4: signature over two in-window stores, one just outside
    do_reset();
    store(32'h0000, 32'hA5, 4'hF, 1'b1);
    store(32'h0004, 32'h3C, 4'hF, 1'b1);
    store(32'h0080, 32'hFFFF_FFFF, 4'hF, 1'b1);
    check("t4_sig", l_sig, 32'h0000_0176);
    check("t4_count", 32'(l_cnt), 32'd2);
    // Byte-0 strobe only: rot(0x176)=0x2EC, ^ 0x00 (lane 0 of 0x1234_5600) = 0x2EC
    store(32'h0008, 32'h1234_5600, 4'h1, 1'b1);
    check("t4_sig_masked", l_sig, 32'h0000_02EC);
    // Load into the window is ignored
    bus_valid = 1'b1; bus_ready = 1'b1; bus_we = 1'b0; bus_addr = 32'h0; bus_wdata = 32'hFF;
    tick();
    bus_valid = 1'b0; bus_ready = 1'b0;
    check("t4_load_ignored", 32'(l_cnt), 32'd3);

    // 5: console pulse; stalled request produces nothing
    do_reset();
    store(32'h0FF4, 32'h41, 4'h1, 1'b1);
    check("t5_con_valid", 32'(l_con_valid), 32'd1);
    check("t5_con_char", 32'(l_con_char), 32'h41);
    tick();
    check("t5_pulse_end", 32'(l_con_valid), 32'd0);
    store(32'h0FF4, 32'h42, 4'h1, 1'b0);
    check("t5_stalled", 32'(l_con_valid), 32'd0);

    // 6: partial-strobe TOHOST ignored, then async reset mid-run
    do_reset();
    store(32'h0FF0, 32'h1, 4'h3, 1'b1);
    check("t6_partial_done", 32'(l_done), 32'd0);
    store(32'h0000, 32'h99, 4'hF, 1'b1);
    check("t6_sig_pre", l_sig, 32'h99);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_sig", l_sig, 32'd0);
    check("t6_async_cnt", 32'(l_cnt), 32'd0);
    check("t6_async_cycles", l_cycles, 32'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
